// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared control encodings for the multi-cycle RV32I controller
//               (states, opcodes, operand/writeback selects, op classes).
//               Also used by the immediate generator and datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4     = 2'd0,
        PC_ALU       = 2'd1,
        PC_ALU_ALIGN = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OPIMM   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd11
    } op_class_e;

    function automatic imm_sel_e imm_sel_of(input op_class_e cls);
        case (cls)
            CLS_OPIMM, CLS_LOAD, CLS_JALR, CLS_SYSTEM: imm_sel_of = IMM_I;
            CLS_STORE:                                 imm_sel_of = IMM_S;
            CLS_BRANCH:                                imm_sel_of = IMM_B;
            CLS_LUI, CLS_AUIPC:                        imm_sel_of = IMM_U;
            CLS_JAL:                                   imm_sel_of = IMM_J;
            default:                                   imm_sel_of = IMM_NONE;
        endcase
    endfunction

    function automatic wb_sel_e wb_sel_of(input op_class_e cls);
        case (cls)
            CLS_LOAD:          wb_sel_of = WB_MEM;
            CLS_JAL, CLS_JALR: wb_sel_of = WB_PC4;
            default:           wb_sel_of = WB_ALU;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_if
// Description : Controller <-> datapath/memory signal bundle. The controller
//               uses the master view; the datapath uses the slave view.
//               Optional macro CTRL_INSTRET_EN adds the instret counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_if;

    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [2:0]  imm_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state_o;
`ifdef CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    modport master (
        input  instr, mem_ready, br_taken,
        output mem_req, mem_we, ir_we, pc_we, pc_src, imm_sel,
               alu_a_sel, alu_b_sel, reg_we, wb_sel, illegal, state_o
`ifdef CTRL_INSTRET_EN
        , output instret
`endif
    );

    modport slave (
        output instr, mem_ready, br_taken,
        input  mem_req, mem_we, ir_we, pc_we, pc_src, imm_sel,
               alu_a_sel, alu_b_sel, reg_we, wb_sel, illegal, state_o
`ifdef CTRL_INSTRET_EN
        , input instret
`endif
    );

endinterface
`default_nettype wire

// File: rtl/ctrl_opdecode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_opdecode
// Description : Combinational opcode classifier: instr[6:0] -> op class,
//               immediate format and legality.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_opdecode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output imm_sel_e   imm_sel,
    output logic       legal
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            c_OPC_OP:     op_class = CLS_OP;
            c_OPC_OPIMM:  op_class = CLS_OPIMM;
            c_OPC_LOAD:   op_class = CLS_LOAD;
            c_OPC_STORE:  op_class = CLS_STORE;
            c_OPC_BRANCH: op_class = CLS_BRANCH;
            c_OPC_JAL:    op_class = CLS_JAL;
            c_OPC_JALR:   op_class = CLS_JALR;
            c_OPC_LUI:    op_class = CLS_LUI;
            c_OPC_AUIPC:  op_class = CLS_AUIPC;
            c_OPC_FENCE:  op_class = CLS_FENCE;
            c_OPC_SYSTEM: op_class = CLS_SYSTEM;
            default:      op_class = CLS_ILLEGAL;
        endcase
    end

    assign imm_sel = imm_sel_of(op_class);
    assign legal   = (op_class != CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm
// Description : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//               Optional macro CTRL_INSTRET_EN adds a retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    ctrl_if.master    bus
);

    state_e    r_state;
    op_class_e r_cls;
    logic      r_mem_req;
    logic      r_mem_we;
    logic      r_reg_we;
    logic      r_alu_a_sel;
    logic      r_alu_b_sel;
    logic      r_illegal;
    wb_sel_e   r_wb_sel;
    imm_sel_e  r_imm_sel;

    op_class_e w_dec_cls;
    imm_sel_e  w_dec_imm;
    logic      w_dec_legal;
    op_class_e w_cls;
    logic      w_is_nop;
    logic      w_fetch_done;
    logic      w_exec_path;
    state_e    w_next;
    logic      w_pc_we;
    pc_src_e   w_pc_src;

    ctrl_opdecode u_opdecode (
        .opcode   (bus.instr[6:0]),
        .op_class (w_dec_cls),
        .imm_sel  (w_dec_imm),
        .legal    (w_dec_legal)
    );

    // The instruction register is only trustworthy from DECODE on, so the
    // class is taken live in DECODE and from the captured copy afterwards.
    assign w_cls        = (r_state == ST_DECODE) ? w_dec_cls : r_cls;
    assign w_is_nop     = (w_cls == CLS_FENCE) || (w_cls == CLS_SYSTEM);
    // mem_req is low for one cycle after reset; no fetch completes without it.
    assign w_fetch_done = (r_state == ST_FETCH) && r_mem_req && bus.mem_ready;
    assign w_exec_path  = (w_next == ST_EXEC) || (w_next == ST_MEM) || (w_next == ST_WB);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_fetch_done) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (!w_dec_legal)  w_next = ST_TRAP;
                else if (w_is_nop) w_next = ST_FETCH;
                else               w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if ((w_cls == CLS_LOAD) || (w_cls == CLS_STORE)) w_next = ST_MEM;
                else if (w_cls == CLS_BRANCH)                    w_next = ST_FETCH;
                else                                             w_next = ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ready) w_next = (w_cls == CLS_STORE) ? ST_FETCH : ST_WB;
            end
            ST_WB:   w_next = ST_FETCH;
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_FETCH;
        endcase
    end

    // Moore outputs are registered against the next state so they are glitch
    // free and valid from the first cycle of each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_cls       <= CLS_FENCE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_alu_a_sel <= 1'b0;
            r_alu_b_sel <= 1'b0;
            r_illegal   <= 1'b0;
            r_wb_sel    <= WB_ALU;
            r_imm_sel   <= IMM_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) r_cls <= w_dec_cls;
            r_mem_req   <= (w_next == ST_FETCH) || (w_next == ST_MEM);
            r_mem_we    <= (w_next == ST_MEM) && (w_cls == CLS_STORE);
            r_reg_we    <= (w_next == ST_WB);
            r_wb_sel    <= (w_next == ST_WB) ? wb_sel_of(w_cls) : WB_ALU;
            r_alu_a_sel <= w_exec_path &&
                           ((w_cls == CLS_AUIPC) || (w_cls == CLS_JAL) || (w_cls == CLS_BRANCH));
            r_alu_b_sel <= w_exec_path && (w_cls != CLS_OP);
            r_imm_sel   <= w_exec_path ? imm_sel_of(w_cls) : IMM_NONE;
            r_illegal   <= (w_next == ST_TRAP);
        end
    end

    always_comb begin
        w_pc_we  = 1'b0;
        w_pc_src = PC_PLUS4;
        case (r_state)
            ST_DECODE: w_pc_we = w_is_nop;
            ST_EXEC: begin
                if (r_cls == CLS_BRANCH) begin
                    w_pc_we  = 1'b1;
                    w_pc_src = bus.br_taken ? PC_ALU : PC_PLUS4;
                end
            end
            ST_MEM: w_pc_we = (r_cls == CLS_STORE) && bus.mem_ready;
            ST_WB: begin
                w_pc_we = 1'b1;
                if (r_cls == CLS_JAL)       w_pc_src = PC_ALU;
                else if (r_cls == CLS_JALR) w_pc_src = PC_ALU_ALIGN;
            end
            default: ;
        endcase
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.ir_we     = w_fetch_done;
    assign bus.pc_we     = w_pc_we;
    assign bus.pc_src    = w_pc_src;
    assign bus.imm_sel   = (r_state == ST_DECODE) ? w_dec_imm : r_imm_sel;
    assign bus.alu_a_sel = r_alu_a_sel;
    assign bus.alu_b_sel = r_alu_b_sel;
    assign bus.reg_we    = r_reg_we;
    assign bus.wb_sel    = r_wb_sel;
    assign bus.illegal   = r_illegal;
    assign bus.state_o   = r_state;

`ifdef CTRL_INSTRET_EN
    logic [31:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_instret <= 32'd0;
        else if (w_pc_we && (r_state != ST_TRAP)) r_instret <= r_instret + 32'd1;
    end

    assign bus.instret = r_instret;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_fsm
// Description : Randomized bench for ctrl_fsm against a per-class phase model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    ctrl_if bus ();

    ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_instret = 32'd0;

    logic [6:0] legal_ops [0:10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                     7'b0010111, 7'b0001111, 7'b1110011};

    typedef struct packed {
        logic       legal;
        logic       nop;
        logic       mem;
        logic       load;
        logic       store;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       chk_alu;
        logic       a_pc;
        logic       b_imm;
        logic [2:0] imm;
    } info_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // What each opcode must do, straight from the instruction-class table.
    function automatic info_t classify(input logic [6:0] opc);
        info_t i;
        i = '0;
        i.legal = 1'b1;
        case (opc)
            7'b0110011: i.chk_alu = 1'b1;
            7'b0010011: begin i.imm = 3'd1; i.b_imm = 1'b1; i.chk_alu = 1'b1; end
            7'b0000011: begin i.imm = 3'd1; i.mem = 1'b1; i.load = 1'b1; i.b_imm = 1'b1; i.chk_alu = 1'b1; end
            7'b0100011: begin i.imm = 3'd2; i.mem = 1'b1; i.store = 1'b1; i.b_imm = 1'b1; i.chk_alu = 1'b1; end
            7'b1100011: begin i.imm = 3'd3; i.branch = 1'b1; i.a_pc = 1'b1; i.b_imm = 1'b1; i.chk_alu = 1'b1; end
            7'b1101111: begin i.imm = 3'd5; i.jal = 1'b1; i.a_pc = 1'b1; i.b_imm = 1'b1; i.chk_alu = 1'b1; end
            7'b1100111: begin i.imm = 3'd1; i.jalr = 1'b1; i.b_imm = 1'b1; i.chk_alu = 1'b1; end
            7'b0110111: i.imm = 3'd4;
            7'b0010111: begin i.imm = 3'd4; i.a_pc = 1'b1; i.b_imm = 1'b1; i.chk_alu = 1'b1; end
            7'b0001111: i.nop = 1'b1;
            7'b1110011: begin i.nop = 1'b1; i.imm = 3'd1; end
            default:    i.legal = 1'b0;
        endcase
        return i;
    endfunction

    // strobes = {mem_req, mem_we, ir_we, pc_we, reg_we, illegal}
    task automatic expect_cycle(input string ph, input state_e st, input logic [5:0] strobes,
                                input int pcsrc, input int wbsel, input int imm);
        chk({ph, ".state"}, 32'(bus.state_o), 32'(st));
        chk({ph, ".strobes"}, 32'({bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.reg_we, bus.illegal}),
            32'(strobes));
        if (strobes[2]) chk({ph, ".pc_src"}, 32'(bus.pc_src), pcsrc);
        if (strobes[1]) chk({ph, ".wb_sel"}, 32'(bus.wb_sel), wbsel);
        if (imm >= 0)   chk({ph, ".imm_sel"}, 32'(bus.imm_sel), imm);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        expect_cycle("reset", ST_FETCH, 6'b000000, 0, 0, 0);
        chk("reset.sels", 32'({bus.pc_src, bus.imm_sel, bus.alu_a_sel, bus.alu_b_sel, bus.wb_sel}), 32'd0);
        exp_instret = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // mem_ready is high but no request is outstanding yet
        expect_cycle("release", ST_FETCH, 6'b000000, 0, 0, -1);
    endtask

    task automatic do_instr(input logic [31:0] ins, input logic br, input int fwait,
                            input int mwait, input bit abort_mem);
        info_t inf;
        logic  rdy;
        inf = classify(ins[6:0]);

        for (int k = 0; k <= fwait; k++) begin
            @(negedge clk);
            rdy = (k == fwait);
            bus.mem_ready = rdy;
            bus.instr     = $urandom();
            bus.br_taken  = 1'($urandom_range(0, 1));
            #1;
            expect_cycle("fetch", ST_FETCH, {1'b1, 1'b0, rdy, 3'b000}, 0, 0, -1);
`ifdef CTRL_INSTRET_EN
            if (k == 0) chk("instret", bus.instret, exp_instret);
`endif
        end

        @(negedge clk);
        bus.instr     = ins;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        expect_cycle("decode", ST_DECODE, {3'b000, inf.nop, 2'b00}, 0, 0, 32'(inf.imm));

        if (!inf.legal) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.br_taken  = 1'($urandom_range(0, 1));
                #1;
                expect_cycle("trap", ST_TRAP, 6'b000001, 0, 0, -1);
            end
            apply_reset();
            return;
        end
        if (inf.nop) begin
            exp_instret++;
            return;
        end

        @(negedge clk);
        bus.br_taken  = br;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        if (inf.chk_alu) chk("exec.alu_sel", 32'({bus.alu_a_sel, bus.alu_b_sel}), 32'({inf.a_pc, inf.b_imm}));
        expect_cycle("exec", ST_EXEC, {3'b000, inf.branch, 2'b00}, (inf.branch && br) ? 1 : 0, 0,
                     32'(inf.imm));
        if (inf.branch) begin
            exp_instret++;
            return;
        end

        if (inf.mem) begin
            for (int k = 0; k <= mwait; k++) begin
                @(negedge clk);
                rdy = abort_mem ? 1'b0 : (k == mwait);
                bus.mem_ready = rdy;
                #1;
                expect_cycle("mem", ST_MEM, {1'b1, inf.store, 1'b0, inf.store & rdy, 2'b00}, 0, 0,
                             32'(inf.imm));
                if (abort_mem) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("abort.mem_req_we", 32'({bus.mem_req, bus.mem_we}), 32'd0);
                    chk("abort.state", 32'(bus.state_o), 32'(ST_FETCH));
                    exp_instret = 32'd0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    bus.mem_ready = 1'b1;
                    #1;
                    expect_cycle("abort.release", ST_FETCH, 6'b000000, 0, 0, -1);
                    return;
                end
            end
            if (inf.store) begin
                exp_instret++;
                return;
            end
        end

        @(negedge clk);
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        expect_cycle("wb", ST_WB, 6'b000110, inf.jal ? 1 : (inf.jalr ? 2 : 0),
                     inf.load ? 1 : ((inf.jal || inf.jalr) ? 2 : 0), 32'(inf.imm));
        exp_instret++;
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  opc;
        rst_n         = 1'b0;
        bus.instr     = 32'd0;
        bus.mem_ready = 1'b0;
        bus.br_taken  = 1'b0;
        apply_reset();

        do_instr(32'h00500093, 1'b0, 0, 0, 1'b0);   // ADDI
        do_instr(32'h0000A103, 1'b0, 0, 3, 1'b0);   // LW, memory late by 3
        do_instr(32'h00208463, 1'b1, 0, 0, 1'b0);   // BEQ taken
        do_instr(32'h00208463, 1'b0, 2, 0, 1'b0);   // BEQ not taken
        do_instr(32'h00112023, 1'b0, 0, 0, 1'b0);   // SW
        do_instr(32'h0000000F, 1'b0, 0, 0, 1'b0);   // FENCE
        do_instr(32'h00000073, 1'b0, 1, 0, 1'b0);   // ECALL as NOP
        do_instr(32'h008000EF, 1'b0, 0, 0, 1'b0);   // JAL
        do_instr(32'h000080E7, 1'b0, 0, 0, 1'b0);   // JALR
        do_instr(32'h000120B7, 1'b0, 0, 0, 1'b0);   // LUI
        do_instr(32'h00001097, 1'b0, 0, 0, 1'b0);   // AUIPC
        do_instr(32'h002081B3, 1'b0, 0, 0, 1'b0);   // ADD
        do_instr(32'h0000007F, 1'b0, 0, 0, 1'b0);   // illegal -> TRAP, reset
        do_instr(32'h00500093, 1'b0, 0, 0, 1'b0);
        do_instr(32'h00112023, 1'b0, 0, 2, 1'b1);   // SW, reset mid-MEM
        do_instr(32'h00112023, 1'b0, 0, 0, 1'b0);

        repeat (300) begin
            r = $urandom();
            if ($urandom_range(0, 19) == 0) begin
                do opc = 7'($urandom()); while (classify(opc).legal);
            end else begin
                opc = legal_ops[$urandom_range(0, 10)];
            end
            do_instr({r[31:7], opc}, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b0);
        end

`ifdef CTRL_INSTRET_EN
        apply_reset();
        dut.r_instret = 32'hFFFF_FFFE;
        exp_instret   = 32'hFFFF_FFFE;
        do_instr(32'h00500093, 1'b0, 0, 0, 1'b0);
        do_instr(32'h0000000F, 1'b0, 0, 0, 1'b0);
        do_instr(32'h00208463, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("instret.wrap", bus.instret, 32'h0000_0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
